conf_regfile_mp: RTL and testbench
==================================

Name: conf_regfile_mp

Overview:
- Parametrised successor to the 16x8 configuration register file.
- Adds independent read ports A and B, a registered read with a valid strobe, per-bit write mask, write-first collision bypass, out-of-range detection and a sticky write-lock region.
- Sits between the host/interface write path and the controllers that consume configuration.
- Holds all configuration registers in one flop array.

Parameters:
- DATA_W, 8: register width in bits.
- DEPTH, 16: number of registers; need not be a power of two.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W >= DEPTH.
- LOCK_BASE, 8: first index of the lockable region. Indices LOCK_BASE..DEPTH-1 become read-only after lock. LOCK_BASE = DEPTH disables locking.
- RST_VAL, 0: reset value of every register, DATA_W bits.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request, one write per cycle.
- wr_addr  in  ADDR_W  write index.
- wr_data  in  DATA_W  write data.
- wr_mask  in  DATA_W  per-bit write enable; 1 = update that bit.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- lock  in  1  pulse to set the sticky lock.
- locked  out  1  current lock state.
- rd_en_a  in  1  port A read request.
- rd_addr_a  in  ADDR_W  port A read index.
- rd_data_a  out  DATA_W  port A read data, registered.
- rd_valid_a  out  1  port A data valid, registered.
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: identical to port A, fully independent.
- rd_err_a, rd_err_b  out  1  registered; the read address was out of range.

Behaviour:
- Reset (sampled at posedge clk while reset=1):
  - All registers load RST_VAL.
  - locked, wr_err, rd_valid_*, rd_err_* go to 0; rd_data_* go to 0.
  - Reset has priority over every other input in that cycle. Inputs during reset are ignored.
- Write: on a cycle with wr_en=1 the write is accepted when wr_addr < DEPTH and not (locked=1 and wr_addr >= LOCK_BASE).
  - Accepted write: for each bit i, reg[wr_addr][i] <= wr_mask[i] ? wr_data[i] : reg[wr_addr][i].
  - wr_mask = 0 is a legal no-op write; wr_err stays 0.
  - Rejected write: array unchanged; wr_err = 1 on the next cycle only.
  - wr_err is 0 whenever wr_en was 0 the previous cycle.
- Lock: lock=1 sets locked on the next cycle.
  - Only reset clears locked.
  - A write in the same cycle as lock, to the lockable region, is still accepted; the lock applies from the following cycle.
- Read, each port independent: read latency is 1 cycle.
  - rd_valid_x(t+1) = rd_en_x(t).
  - rd_data_x(t+1) = contents of rd_addr_x at t, after any write accepted at t (write-first bypass). The bypass applies the mask, so unmasked bits return the old value.
  - With rd_en_x=0, rd_data_x holds its last value and rd_valid_x=0.
  - Out-of-range read (rd_addr_x >= DEPTH): rd_data_x <= 0, rd_err_x <= 1, rd_valid_x <= 1.
  - Both ports may read the same address in one cycle; both return identical data.
- Rejected writes are never bypassed to readers.
- No state machine beyond the lock flag and the output registers. All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro CONF_REGF_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, recomputed on every accepted write over the post-mask value.
  - Outputs rd_perr_a and rd_perr_b (1 bit, registered, aligned with rd_valid) assert when the stored parity mismatches the stored data.
  - Bypassed reads report rd_perr = 0.
  - Input inj_perr (1 bit) inverts the stored parity bit of the entry written in that cycle, for fault injection.
- Undefined: no parity storage and none of these ports exist.

Test Plan:
- Reset then read all indices on A and B -> every rd_data = RST_VAL, rd_valid = 1 one cycle after rd_en, no rd_err.
- Write 0xA5 mask 0xFF to addr 3; next cycle write 0x5A mask 0x0F to addr 3; then read A at addr 3 -> 0xAA.
- Same cycle: wr_en addr 5 data 0x3C mask 0xFF, plus rd_en_a addr 5 and rd_en_b addr 5 -> both ports return 0x3C next cycle (bypass).
- Pulse lock, then write 0x11 to addr 9 (LOCK_BASE=8) -> wr_err pulses one cycle, addr 9 unchanged. Write 0x22 to addr 2 -> accepted, wr_err stays 0.
- DEPTH=12: write to addr 13 -> wr_err pulses; read A at addr 14 -> rd_data_a = 0, rd_err_a = 1, rd_valid_a = 1.
- Assert reset during a locked, back-to-back read burst -> next cycle locked = 0, rd_valid_* = 0, registers = RST_VAL; a write to addr 9 after reset is accepted.

Source files
------------

// File: rtl/conf_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : conf_regfile_mp
// Purpose  : Parametrised configuration register file. One masked write port,
//            two independent registered read ports (A/B) with valid strobes,
//            write-first bypass, out-of-range detection and a sticky lock
//            that makes entries LOCK_BASE..DEPTH-1 read-only.
// Ports    : clk, reset (sync, active-high)
//            wr_en/wr_addr/wr_data/wr_mask -> write request, wr_err pulse
//            lock -> sets sticky locked flag (locked output)
//            rd_en_x/rd_addr_x -> rd_data_x/rd_valid_x/rd_err_x (x = a, b)
// Option   : CONF_REGF_PARITY_EN adds per-entry even parity, inj_perr input
//            and rd_perr_a/rd_perr_b outputs.
// Revision : 1.0 - initial release
// ============================================================================
module conf_regfile_mp #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = 4,
    parameter int                LOCK_BASE = 8,
    parameter logic [DATA_W-1:0] RST_VAL   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    output logic              wr_err,
    input  logic              lock,
    output logic              locked,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    output logic              rd_err_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
`ifdef CONF_REGF_PARITY_EN
    input  logic              inj_perr,
    output logic              rd_perr_a,
    output logic              rd_perr_b,
`endif
    output logic              rd_err_b
);

    // One extra bit so DEPTH == 2**ADDR_W and LOCK_BASE == DEPTH both fit.
    localparam logic [ADDR_W:0] c_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_LOCK_BASE = (ADDR_W+1)'(LOCK_BASE);
    localparam int              c_NPORT     = 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q      [DEPTH];
    logic              locked_q;
    logic              wr_err_q;
    logic [DATA_W-1:0] rd_data_q  [c_NPORT];
    logic              rd_valid_q [c_NPORT];
    logic              rd_err_q   [c_NPORT];

    // ------------------------------------------------------------------
    // Write path: accept check and post-mask value
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_val;
    logic              wr_ok;

    always_comb begin
        wr_old = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                wr_old = mem_q[i];
            end
        end
        wr_val = (wr_old & ~wr_mask) | (wr_data & wr_mask);
        wr_ok  = wr_en && ({1'b0, wr_addr} < c_DEPTH) &&
                 !(locked_q && ({1'b0, wr_addr} >= c_LOCK_BASE));
    end

    // ------------------------------------------------------------------
    // Read path: ports handled as a 2-entry array to keep A and B identical
    // ------------------------------------------------------------------
    logic              rd_en   [c_NPORT];
    logic [ADDR_W-1:0] rd_addr [c_NPORT];
    logic [DATA_W-1:0] rd_data_d [c_NPORT];
    logic              rd_err_d  [c_NPORT];
    logic              rd_byp    [c_NPORT];

    assign rd_en[0]   = rd_en_a;
    assign rd_en[1]   = rd_en_b;
    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    always_comb begin
        for (int p = 0; p < c_NPORT; p++) begin
            rd_data_d[p] = '0;
            rd_err_d[p]  = 1'b0;
            // Bypass only an accepted write; rejected writes never reach readers.
            rd_byp[p]    = wr_ok && (wr_addr == rd_addr[p]);
            if ({1'b0, rd_addr[p]} >= c_DEPTH) begin
                rd_err_d[p] = 1'b1;
            end else if (rd_byp[p]) begin
                rd_data_d[p] = wr_val;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_addr[p] == ADDR_W'(i)) begin
                        rd_data_d[p] = mem_q[i];
                    end
                end
            end
        end
    end

`ifdef CONF_REGF_PARITY_EN
    logic par_q     [DEPTH];
    logic rd_perr_q [c_NPORT];
    logic rd_perr_d [c_NPORT];

    // Stored parity is compared against stored data; bypassed data is fresh.
    always_comb begin
        for (int p = 0; p < c_NPORT; p++) begin
            rd_perr_d[p] = 1'b0;
            if (({1'b0, rd_addr[p]} < c_DEPTH) && !rd_byp[p]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_addr[p] == ADDR_W'(i)) begin
                        rd_perr_d[p] = par_q[i] ^ (^mem_q[i]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= ^RST_VAL;
            end
            for (int p = 0; p < c_NPORT; p++) begin
                rd_perr_q[p] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    par_q[i] <= (^wr_val) ^ inj_perr;
                end
            end
            for (int p = 0; p < c_NPORT; p++) begin
                rd_perr_q[p] <= rd_en[p] && rd_perr_d[p];
            end
        end
    end

    assign rd_perr_a = rd_perr_q[0];
    assign rd_perr_b = rd_perr_q[1];
`endif

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
            locked_q <= 1'b0;
            wr_err_q <= 1'b0;
            for (int p = 0; p < c_NPORT; p++) begin
                rd_data_q[p]  <= '0;
                rd_valid_q[p] <= 1'b0;
                rd_err_q[p]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    mem_q[i] <= wr_val;
                end
            end
            // Lock is evaluated after this cycle's write check, so a write
            // alongside the lock pulse still lands.
            locked_q <= locked_q | lock;
            wr_err_q <= wr_en && !wr_ok;
            for (int p = 0; p < c_NPORT; p++) begin
                rd_valid_q[p] <= rd_en[p];
                rd_err_q[p]   <= rd_en[p] && rd_err_d[p];
                if (rd_en[p]) begin
                    rd_data_q[p] <= rd_data_d[p];
                end
            end
        end
    end

    assign wr_err     = wr_err_q;
    assign locked     = locked_q;
    assign rd_data_a  = rd_data_q[0];
    assign rd_valid_a = rd_valid_q[0];
    assign rd_err_a   = rd_err_q[0];
    assign rd_data_b  = rd_data_q[1];
    assign rd_valid_b = rd_valid_q[1];
    assign rd_err_b   = rd_err_q[1];

endmodule
`default_nettype wire

// File: tb/tb_conf_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_conf_regfile_mp
// Purpose  : Self-checking bench for conf_regfile_mp. A reference model of the
//            array and lock flag predicts read results, which are queued when
//            a read is issued and popped when the DUT raises rd_valid.
//            A second instance with DEPTH=12 covers out-of-range handling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conf_regfile_mp;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (DEPTH=16, LOCK_BASE=8)
    logic       reset, wr_en, lock, rd_en_a, rd_en_b;
    logic [3:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [7:0] wr_data, wr_mask;
    logic       wr_err, locked, rd_valid_a, rd_valid_b, rd_err_a, rd_err_b;
    logic [7:0] rd_data_a, rd_data_b;

    conf_regfile_mp dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_err(wr_err), .lock(lock), .locked(locked),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_valid_a(rd_valid_a), .rd_err_a(rd_err_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .rd_valid_b(rd_valid_b), .rd_err_b(rd_err_b)
    );

    // Small DUT (DEPTH=12)
    logic       s_reset, s_wr_en, s_lock, s_rd_en_a, s_rd_en_b;
    logic [3:0] s_wr_addr, s_rd_addr_a, s_rd_addr_b;
    logic [7:0] s_wr_data, s_wr_mask;
    logic       s_wr_err, s_locked, s_rd_valid_a, s_rd_valid_b, s_rd_err_a, s_rd_err_b;
    logic [7:0] s_rd_data_a, s_rd_data_b;

    conf_regfile_mp #(.DEPTH(12)) dut12 (
        .clk(clk), .reset(s_reset),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_mask(s_wr_mask),
        .wr_err(s_wr_err), .lock(s_lock), .locked(s_locked),
        .rd_en_a(s_rd_en_a), .rd_addr_a(s_rd_addr_a), .rd_data_a(s_rd_data_a),
        .rd_valid_a(s_rd_valid_a), .rd_err_a(s_rd_err_a),
        .rd_en_b(s_rd_en_b), .rd_addr_b(s_rd_addr_b), .rd_data_b(s_rd_data_b),
        .rd_valid_b(s_rd_valid_b), .rd_err_b(s_rd_err_b)
    );

    // ------------------------------------------------------------------
    // Checking and model state
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       e;
    } rd_t;

    rd_t        qa[$];
    rd_t        qb[$];
    logic [7:0] mdl [16];
    bit         mdl_lock;
    logic [7:0] last_a, last_b;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mdl_lock = 1'b0;
        qa.delete();
        qb.delete();
        last_a = 8'h00;
        last_b = 8'h00;
    endtask

    // Drive one cycle of stimulus, predict, then check #1 after the edge.
    task automatic cycle(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                         input logic [7:0] wm, input bit lk,
                         input bit rea, input logic [3:0] ra,
                         input bit reb, input logic [3:0] rb);
        bit  ok, exp_err;
        rd_t e;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm; lock = lk;
        rd_en_a = rea; rd_addr_a = ra; rd_en_b = reb; rd_addr_b = rb;

        ok      = we && !(mdl_lock && (wa >= 4'd8));
        exp_err = we && !ok;
        if (ok) mdl[wa] = (mdl[wa] & ~wm) | (wd & wm);
        if (lk) mdl_lock = 1'b1;
        if (rea) begin e.d = mdl[ra]; e.e = 1'b0; qa.push_back(e); end
        if (reb) begin e.d = mdl[rb]; e.e = 1'b0; qb.push_back(e); end

        @(posedge clk); #1;
        check("wr_err", wr_err, exp_err);
        check("locked", locked, mdl_lock);
        check("rd_valid_a", rd_valid_a, rea);
        check("rd_valid_b", rd_valid_b, reb);
        if (rd_valid_a) begin
            if (qa.size() == 0) check("sb_a_underrun", qa.size(), 1);
            else begin
                e = qa.pop_front();
                check("rd_data_a", rd_data_a, e.d);
                check("rd_err_a", rd_err_a, e.e);
                last_a = e.d;
            end
        end else check("hold_a", rd_data_a, last_a);
        if (rd_valid_b) begin
            if (qb.size() == 0) check("sb_b_underrun", qb.size(), 1);
            else begin
                e = qb.pop_front();
                check("rd_data_b", rd_data_b, e.d);
                check("rd_err_b", rd_err_b, e.e);
                last_b = e.d;
            end
        end else check("hold_b", rd_data_b, last_b);
    endtask

    task automatic idle();
        cycle(0, 4'd0, 8'h00, 8'h00, 0, 0, 4'd0, 0, 4'd0);
    endtask

    // Reset with busy inputs: everything must be ignored.
    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'hEE; wr_mask = 8'hFF; lock = 1'b1;
        rd_en_a = 1'b1; rd_addr_a = 4'd9; rd_en_b = 1'b1; rd_addr_b = 4'd3;
        @(posedge clk); #1;
        check("rst_locked", locked, 1'b0);
        check("rst_wr_err", wr_err, 1'b0);
        check("rst_valid_a", rd_valid_a, 1'b0);
        check("rst_valid_b", rd_valid_b, 1'b0);
        check("rst_err_a", rd_err_a, 1'b0);
        check("rst_data_a", rd_data_a, 8'h00);
        check("rst_data_b", rd_data_b, 8'h00);
        reset = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; wr_mask = 0; lock = 0;
        rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0;
        s_reset = 1'b1; s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_wr_mask = 0;
        s_lock = 0; s_rd_en_a = 0; s_rd_addr_a = 0; s_rd_en_b = 0; s_rd_addr_b = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // All entries read back as reset value on both ports.
        for (int i = 0; i < 16; i++)
            cycle(0, 4'd0, 8'h00, 8'h00, 0, 1, 4'(i), 1, 4'(15 - i));
        idle();

        // Masked update: A5 then 5A under mask 0F gives AA.
        cycle(1, 4'd3, 8'hA5, 8'hFF, 0, 0, 4'd0, 0, 4'd0);
        cycle(1, 4'd3, 8'h5A, 8'h0F, 0, 0, 4'd0, 0, 4'd0);
        cycle(0, 4'd0, 8'h00, 8'h00, 0, 1, 4'd3, 0, 4'd0);
        // Zero mask is a no-op write, no error.
        cycle(1, 4'd3, 8'hFF, 8'h00, 0, 1, 4'd3, 1, 4'd3);
        // Partial-mask bypass returns old bits for unmasked positions.
        cycle(1, 4'd3, 8'h0F, 8'hF0, 0, 1, 4'd3, 0, 4'd0);
        // Full bypass on both ports.
        cycle(1, 4'd5, 8'h3C, 8'hFF, 0, 1, 4'd5, 1, 4'd5);
        idle();

        // Write alongside lock pulse lands; later locked-region write rejected.
        cycle(1, 4'd10, 8'h77, 8'hFF, 1, 1, 4'd10, 0, 4'd0);
        cycle(1, 4'd9, 8'h11, 8'hFF, 0, 1, 4'd9, 1, 4'd9);
        cycle(1, 4'd2, 8'h22, 8'hFF, 0, 1, 4'd2, 0, 4'd0);
        cycle(0, 4'd0, 8'h00, 8'h00, 0, 1, 4'd9, 1, 4'd10);
        cycle(1, 4'd8, 8'h44, 8'hFF, 0, 0, 4'd0, 1, 4'd8);

        // Locked back-to-back burst, then reset in the middle of it.
        for (int i = 0; i < 4; i++)
            cycle(0, 4'd0, 8'h00, 8'h00, 0, 1, 4'(8 + i), 1, 4'(i));
        do_reset();
        cycle(1, 4'd9, 8'h99, 8'hFF, 0, 1, 4'd9, 1, 4'd10);
        cycle(0, 4'd0, 8'h00, 8'h00, 0, 1, 4'd9, 0, 4'd0);

        // Randomised traffic; occasional lock, one mid-run reset.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            cycle(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  8'($urandom), 8'($urandom), bit'($urandom_range(0, 59) == 0),
                  bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        idle();
        check("sb_a_drain", qa.size(), 0);
        check("sb_b_drain", qb.size(), 0);

        // DEPTH=12 instance: out-of-range handling.
        s_reset = 1'b0;
        s_wr_en = 1'b1; s_wr_addr = 4'd13; s_wr_data = 8'hFF; s_wr_mask = 8'hFF;
        @(posedge clk); #1;
        check("d12_wr_err_oor", s_wr_err, 1'b1);
        s_wr_addr = 4'd11; s_wr_data = 8'h5C;
        s_rd_en_a = 1'b1; s_rd_addr_a = 4'd11;
        @(posedge clk); #1;
        check("d12_wr_err_ok", s_wr_err, 1'b0);
        check("d12_byp_data", s_rd_data_a, 8'h5C);
        check("d12_byp_err", s_rd_err_a, 1'b0);
        s_wr_en = 1'b0; s_rd_addr_a = 4'd14; s_rd_en_b = 1'b1; s_rd_addr_b = 4'd12;
        @(posedge clk); #1;
        check("d12_oor_valid", s_rd_valid_a, 1'b1);
        check("d12_oor_err_a", s_rd_err_a, 1'b1);
        check("d12_oor_data_a", s_rd_data_a, 8'h00);
        check("d12_oor_err_b", s_rd_err_b, 1'b1);
        s_rd_addr_a = 4'd11; s_rd_en_b = 1'b0;
        @(posedge clk); #1;
        check("d12_read11", s_rd_data_a, 8'h5C);
        check("d12_read11_err", s_rd_err_a, 1'b0);
        check("d12_valid_b_off", s_rd_valid_b, 1'b0);
        s_rd_en_a = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
